// File: rtl/sbox_layer_mc.sv
// Multi-cycle S-box layer: substitutes LANES nibbles per enabled cycle of a DATA_W-bit word.
// Define SBOX_LAYER_INV_EN to build in the inverse table, selected by datab[0] at start.
module sbox_layer_mc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LANES  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [DATA_W-1:0] dataa,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] result,
  output logic              done
);

  localparam int unsigned N  = DATA_W / 4;
  localparam int unsigned R  = N / LANES;
  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned SW = 4 * LANES;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] work_q, work_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              done_q, done_d;
  logic [SW-1:0]     sub;
  logic [DATA_W-1:0] sub_ext;
  logic              last_round;

  function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h9;  4'h2: y = 4'hD;  4'h3: y = 4'h2;
      4'h4: y = 4'h5;  4'h5: y = 4'hF;  4'h6: y = 4'h3;  4'h7: y = 4'h6;
      4'h8: y = 4'h7;  4'h9: y = 4'hE;  4'hA: y = 4'h0;  4'hB: y = 4'h1;
      4'hC: y = 4'hA;  4'hD: y = 4'h4;  4'hE: y = 4'hB;  default: y = 4'h8;
    endcase
    return y;
  endfunction

`ifdef SBOX_LAYER_INV_EN
  logic mode_q, mode_d;
  logic unused_datab;
  assign unused_datab = ^datab[DATA_W-1:1];

  function automatic logic [3:0] sbox_inv(input logic [3:0] x);
    logic [3:0] y;
    unique case (x)
      4'h0: y = 4'hA;  4'h1: y = 4'hB;  4'h2: y = 4'h3;  4'h3: y = 4'h6;
      4'h4: y = 4'hD;  4'h5: y = 4'h4;  4'h6: y = 4'h7;  4'h7: y = 4'h8;
      4'h8: y = 4'hF;  4'h9: y = 4'h1;  4'hA: y = 4'hC;  4'hB: y = 4'hE;
      4'hC: y = 4'h0;  4'hD: y = 4'h2;  4'hE: y = 4'h9;  default: y = 4'h5;
    endcase
    return y;
  endfunction

  always_comb begin
    sub = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sub[4*i +: 4] = mode_q ? sbox_inv(work_q[4*i +: 4]) : sbox_fwd(work_q[4*i +: 4]);
    end
  end
`else
  logic unused_datab;
  assign unused_datab = ^datab;

  always_comb begin
    sub = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sub[4*i +: 4] = sbox_fwd(work_q[4*i +: 4]);
    end
  end
`endif

  // Substituted lanes enter at the top so the first round ends up in the low nibbles.
  always_comb begin
    sub_ext          = '0;
    sub_ext[SW-1:0]  = sub;
  end

  assign last_round = (cnt_q == CW'(R - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    result_d = result_q;
    done_d   = (state_q == StDone);
`ifdef SBOX_LAYER_INV_EN
    mode_d   = mode_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = dataa;
          cnt_d   = '0;
          state_d = StRun;
`ifdef SBOX_LAYER_INV_EN
          mode_d  = datab[0];
`endif
        end
      end
      StRun: begin
        work_d   = work_q >> SW;
        result_d = (result_q >> SW) | (sub_ext << (DATA_W - SW));
        if (last_round) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      work_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef SBOX_LAYER_INV_EN
      mode_q   <= 1'b0;
`endif
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef SBOX_LAYER_INV_EN
      mode_q   <= mode_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_sbox_layer_mc.sv
// Randomised and directed bench for sbox_layer_mc against a nibble-table reference model.
module tb_sbox_layer_mc;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 1;
  localparam int unsigned N      = DATA_W / 4;
  localparam int unsigned R      = N / LANES;

  logic              clk     = 1'b0;
  logic              reset_n = 1'b0;
  logic              clk_en  = 1'b1;
  logic              start   = 1'b0;
  logic [DATA_W-1:0] dataa   = '0;
  logic [DATA_W-1:0] datab   = '0;
  logic [DATA_W-1:0] result;
  logic              done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sbox_layer_mc #(
    .DATA_W (DATA_W),
    .LANES  (LANES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .clk_en  (clk_en),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .result  (result),
    .done    (done)
  );

  logic [3:0] fwd_t [16] = '{4'hC, 4'h9, 4'hD, 4'h2, 4'h5, 4'hF, 4'h3, 4'h6,
                             4'h7, 4'hE, 4'h0, 4'h1, 4'hA, 4'h4, 4'hB, 4'h8};
  logic [3:0] inv_t [16] = '{4'hA, 4'hB, 4'h3, 4'h6, 4'hD, 4'h4, 4'h7, 4'h8,
                             4'hF, 4'h1, 4'hC, 4'hE, 4'h0, 4'h2, 4'h9, 4'h5};

  function automatic logic [DATA_W-1:0] ref_sbox(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    logic              inv;
    logic [3:0]        nib;
`ifdef SBOX_LAYER_INV_EN
    inv = b[0];
`else
    inv = 1'b0 & b[0];
`endif
    r = '0;
    for (int i = 0; i < int'(N); i++) begin
      nib = a[4*i +: 4];
      r[4*i +: 4] = inv ? inv_t[nib] : fwd_t[nib];
    end
    return r;
  endfunction

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] obs,
                          input logic [DATA_W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // stall: 0 none, 1 clk_en low 3 cycles mid-run with start held, 2 clk_en low while done high
  task automatic run_op(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] exp_res, input int stall);
    int k;
    bit got;
    int exp_k;
    logic [DATA_W-1:0] held;
    @(negedge clk);
    dataa  = a;
    datab  = b;
    start  = 1'b1;
    clk_en = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dataa = $urandom;
    datab = $urandom;
    k     = 0;
    got   = 1'b0;
    while (!got && k < 60) begin
      @(posedge clk);
      #1;
      k++;
      if (done) got = 1'b1;
      else if (stall == 1 && k == 3) begin
        clk_en = 1'b0;
        start  = 1'b1;
        dataa  = $urandom;
      end else if (stall == 1 && k == 6) clk_en = 1'b1;
      else if (stall == 1 && k == 7) start = 1'b0;
    end
    start  = 1'b0;
    clk_en = 1'b1;
    exp_k  = int'(R) + 1 + ((stall == 1) ? 3 : 0);
    check_eq("latency", DATA_W'(k), DATA_W'(exp_k));
    check_eq("result", result, exp_res);
    held = result;
    if (stall == 2) begin
      clk_en = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("done_frozen", DATA_W'(done), DATA_W'(1));
      check_eq("result_frozen", result, exp_res);
      clk_en = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("done_pulse_end", DATA_W'(done), DATA_W'(0));
    check_eq("result_hold", result, held);
  endtask

  initial begin
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    int pulses;

    #12;
    check_eq("reset_done", DATA_W'(done), DATA_W'(0));
    check_eq("reset_result", result, '0);
    @(negedge clk);
    reset_n = 1'b1;

    run_op(32'h01234567, 32'h0, 32'hC9D25F36, 0);
    if (R >= 4) run_op(32'h89ABCDEF, 32'h0, 32'h7E01A4B8, 1);
    else        run_op(32'h89ABCDEF, 32'h0, 32'h7E01A4B8, 0);
`ifdef SBOX_LAYER_INV_EN
    run_op(32'hC9D25F36, 32'h1, 32'h01234567, 0);
    run_op(32'h7E01A4B8, 32'h1, 32'h89ABCDEF, 0);
`else
    run_op(32'h01234567, 32'h1, 32'hC9D25F36, 0);
    run_op(32'h89ABCDEF, 32'hFFFFFFFF, 32'h7E01A4B8, 0);
`endif
    a = $urandom;
    b = $urandom;
    run_op(a, b, ref_sbox(a, b), 2);
    for (int i = 0; i < 12; i++) begin
      a = $urandom;
      b = $urandom;
      run_op(a, b, ref_sbox(a, b), 0);
    end

    // Abort mid-operation with an asynchronous reset.
    @(negedge clk);
    dataa = 32'h01234567;
    datab = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("abort_done", DATA_W'(done), DATA_W'(0));
    check_eq("abort_result", result, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < int'(R) + 4; i++) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check_eq("abort_no_done", DATA_W'(pulses), DATA_W'(0));
    run_op(32'hFFFFFFFF, 32'h0, 32'h88888888, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sbox_layer_mc.md
# sbox_layer_mc

Multi-cycle custom-instruction S-box layer: substitutes every 4-bit nibble of a DATA_W-bit operand through the team's 4-bit S-box, LANES nibbles per clock. Generalises the single-nibble combinational S-box helper to a full-word, parametrised, optionally invertible datapath. It sits on the processor's multi-cycle custom-instruction port (clk_en/start/done handshake) and serves the cipher's substitution step in both the encrypt and decrypt paths.

## Interface
- DATA_W, 32: operand/result width; a multiple of 4; nibble count N = DATA_W/4.
- LANES, 1: nibbles substituted per cycle; must divide N evenly; rounds R = N/LANES.
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clk_en  in  1  clock qualifier; when low, all registers hold their value.
- start  in  1  begin an operation; sampled only in IDLE with clk_en high.
- dataa  in  DATA_W  operand to substitute; captured with start.
- datab  in  DATA_W  bit 0 = mode (0 forward, 1 inverse), captured with start; other bits ignored.
- result  out  DATA_W  substituted word; valid while done is high, held until the next start.
- done  out  1  one-cycle completion pulse.

## Operation
- Forward S-box, input 0..F -> C 9 D 2 5 F 3 6 7 E 0 1 A 4 B 8.
- Inverse S-box, input 0..F -> A B 3 6 D 4 7 8 F 1 C E 0 2 9 5.
- Nibble i = bits [4i+3:4i]; each nibble maps independently, position-preserving.
- FSM states: IDLE, RUN, DONE.
- IDLE: on start with clk_en high, load working register from dataa, latch mode, clear round counter, go RUN.
- RUN: each enabled cycle substitute the LANES lowest nibbles of the working register, shift the working register right by 4*LANES, shift substituted nibbles in at the top of the result register; increment the counter. After round R-1, go DONE.
- DONE: done = 1 for exactly one enabled cycle, result holds the final word; next state IDLE.
- start in RUN or DONE is ignored; a new operation may start in the cycle after done.
- Round counter width: clog2(R), minimum 1 bit; no wrap beyond R-1.

## Timing
- Reset values: done = 0, result = 0, state IDLE, counter 0, working register 0, mode 0.
- Latency: start accepted at edge 0; done high after edge R+1 (LANES=1, DATA_W=32: done high during cycle 9); LANES=8 gives done in cycle 2.
- clk_en low in any state freezes state, counter, working register, result, and the done level; done stays high for one enabled cycle.
- Reset asserted mid-operation: immediate return to reset values; no done pulse for the aborted operation.
- result changes only during RUN; it is stable from done until the next accepted start.
- dataa/datab may change after the start cycle without effect.

## Configuration
- SBOX_LAYER_INV_EN defined: inverse table built in; datab[0] selects forward or inverse.
- SBOX_LAYER_INV_EN undefined: only the forward table exists; mode register removed; datab fully ignored; forward results identical to the defined build.

## Test plan
- Forward, LANES=1: dataa=0x01234567, datab=0 -> done in cycle 9, result=0xC9D25F36.
- Inverse (macro defined): dataa=0xC9D25F36, datab=1 -> result=0x01234567; dataa=0x89ABCDEF, datab=0 -> 0x7E01A4B8, then the inverse operation returns 0x89ABCDEF.
- LANES=8 and LANES=2 builds, dataa=0x89ABCDEF -> result 0x7E01A4B8 with done in cycle 2 and cycle 5 respectively.
- clk_en held low for 3 cycles mid-RUN, plus start pulses during RUN -> done delayed by exactly 3 cycles, result unchanged, extra starts ignored.
- reset_n pulsed low at round 4 -> done=0 and result=0 immediately; a fresh start of 0xFFFFFFFF then yields 0x88888888.
- Macro undefined, datab=1, dataa=0x01234567 -> 0xC9D25F36 (forward only).
